// File: rtl/dac_sample_sequencer_pkg.sv
// dac_seq_pkg: shared state type, default sizes and occupancy-width helper for the DAC sample sequencer
package dac_seq_pkg;
  localparam int DATA_W_DEF = 10;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int DIV_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dac_sample_sequencer_if.sv
// dac_sample_sequencer_if: valid/ready sample stream from the core into the sequencer
interface dac_sample_sequencer_if import dac_seq_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic s_valid;
  logic [DATA_W-1:0] s_data;
  logic s_ready;
  modport master (output s_valid, s_data, input s_ready);
  modport slave (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/dac_sample_sequencer_fifo.sv
// sync_fifo: single-clock power-of-two FIFO with occupancy count and no push-to-pop bypass
module sync_fifo import dac_seq_pkg::*; #(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [occ_w(DEPTH)-1:0]  level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = occ_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer: paces buffered core samples onto the DAC at a fixed div+1 cycle period
module dac_sample_sequencer import dac_seq_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              div,
  dac_sample_sequencer_if.slave         s,
  output logic [DATA_W-1:0]             dac_d,
  output logic                          dac_en,
  output logic                          underrun,
  output logic [occ_w(FIFO_DEPTH)-1:0]  level
);
  state_t state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] head;
  logic pop, full, empty, underrun_nxt;
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(s.s_valid),
    .din(s.s_data),
    .pop(pop),
    .dout(head),
    .level(level),
    .full(full),
    .empty(empty)
  );
  assign s.s_ready = !full;
  assign dac_en = state == RUN;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    pop = 1'b0;
    underrun_nxt = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
    end else if (state == IDLE) begin
      state_nxt = PRIME;
    end else if (state == PRIME) begin
      state_nxt = empty ? PRIME : RUN;
      cnt_nxt = empty ? cnt : div;
      pop = !empty;
    end else if (cnt == '0) begin
      cnt_nxt = div;
      pop = !empty;
      underrun_nxt = empty;
    end else begin
      cnt_nxt = cnt - DIV_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      dac_d <= '0;
      underrun <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      underrun <= underrun_nxt;
      if (pop) dac_d <= head;
    end
  end
endmodule

// File: tb/tb_dac_sample_sequencer.sv
// tb_dac_sample_sequencer: directed and randomized steps checked against a queue-based tick-grid model
module tb_dac_sample_sequencer;
  import dac_seq_pkg::*;
  localparam int DW = 10;
  localparam int DEPTH = 4;
  localparam int DVW = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [DVW-1:0] div = '0;
  logic [DW-1:0] dac_d;
  logic dac_en, underrun;
  logic [occ_w(DEPTH)-1:0] level;
  int n_cmp = 0;
  int n_err = 0;
  int un_cnt = 0;
  logic [DW-1:0] q[$];
  int mode = 0;
  int cyc = 0;
  int next_tick = 0;
  logic [DW-1:0] m_d = '0;
  logic m_en = 1'b0;
  logic m_un = 1'b0;
  dac_sample_sequencer_if #(.DATA_W(DW)) sif();
  dac_sample_sequencer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV_W(DVW)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .div(div),
    .s(sif),
    .dac_d(dac_d),
    .dac_en(dac_en),
    .underrun(underrun),
    .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  // mode 0/1/2 = stopped / waiting for first sample / pacing; ticks sit on an absolute cycle grid
  task automatic model(input logic r, input logic e, input logic v, input logic [DW-1:0] d);
    bit was_full;
    cyc++;
    if (r) begin
      q.delete();
      mode = 0;
      m_d = '0;
      m_en = 1'b0;
      m_un = 1'b0;
    end else begin
      was_full = q.size() == DEPTH;
      m_un = 1'b0;
      if (!e) begin
        mode = 0;
        m_en = 1'b0;
      end else if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (q.size() > 0) begin
          m_d = q.pop_front();
          m_en = 1'b1;
          mode = 2;
          next_tick = cyc + int'(div) + 1;
        end
      end else if (cyc == next_tick) begin
        next_tick = cyc + int'(div) + 1;
        if (q.size() > 0) m_d = q.pop_front();
        else m_un = 1'b1;
      end
      if (v && !was_full) q.push_back(d);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic v, input logic [DW-1:0] d);
    reset = r;
    enable = e;
    sif.s_valid = v;
    sif.s_data = d;
    @(posedge clk);
    model(r, e, v, d);
    #1;
    chk("dac_d", 32'(dac_d), 32'(m_d));
    chk("dac_en", 32'(dac_en), 32'(m_en));
    chk("underrun", 32'(underrun), 32'(m_un));
    chk("level", 32'(level), 32'(q.size()));
    chk("s_ready", 32'(sif.s_ready), 32'(q.size() != DEPTH));
    if (underrun) un_cnt++;
  endtask
  initial begin
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_dac_d", 32'(dac_d), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_s_ready", 32'(sif.s_ready), 1);
    for (int i = 1; i <= 3; i++) step(0, 0, 1, DW'(i));
    step(0, 0, 0, 0);
    chk("idle_fill_level", 32'(level), 3);
    chk("idle_fill_dac_en", 32'(dac_en), 0);
    chk("idle_fill_dac_d", 32'(dac_d), 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 10'h100);
    step(0, 0, 1, 10'h200);
    step(0, 0, 1, 10'h3ff);
    div = 16'd4;
    un_cnt = 0;
    for (int i = 0; i < 18; i++) step(0, 1, 0, 0);
    chk("div4_underruns", 32'(un_cnt), 1);
    chk("div4_hold", 32'(dac_d), 32'h3ff);
    step(0, 0, 0, 0);
    div = 16'd0;
    un_cnt = 0;
    for (int i = 0; i < 40; i++) step(0, 1, 1, DW'(i));
    chk("div0_underruns", 32'(un_cnt), 0);
    chk("div0_level", 32'(level), 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, DW'($urandom));
    chk("full_level", 32'(level), 4);
    chk("full_ready", 32'(sif.s_ready), 0);
    div = 16'd2;
    for (int i = 0; i < 12; i++) step(0, 1, 1, DW'($urandom));
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, DW'($urandom));
    div = 16'd9;
    for (int i = 0; i < 8; i++) step(0, 1, 1'($urandom_range(0, 1)), DW'($urandom));
    step(0, 0, 0, 0);
    chk("stop_dac_en", 32'(dac_en), 0);
    step(0, 0, 1, DW'($urandom));
    step(0, 0, 0, 0);
    for (int i = 0; i < 25; i++) step(0, 1, 1'($urandom_range(0, 1)), DW'($urandom));
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, DW'($urandom));
    div = 16'd3;
    for (int k = 0; k < 40 && !(mode == 2 && q.size() == 2); k++) step(0, 1, 0, 0);
    chk("prereset_level", 32'(level), 2);
    chk("prereset_dac_en", 32'(dac_en), 1);
    step(1, 1, 0, 0);
    chk("midrun_rst_level", 32'(level), 0);
    chk("midrun_rst_dac_en", 32'(dac_en), 0);
    chk("midrun_rst_dac_d", 32'(dac_d), 0);
    chk("midrun_rst_underrun", 32'(underrun), 0);
    for (int i = 0; i < 600; i++) begin
      if (i % 37 == 0) div = DVW'($urandom_range(0, 6));
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 2) != 0), DW'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
